// File: rtl/hv_pkg.sv
// Shared types and defaults for the HV fault monitor.
package hv_pkg;

  localparam int HV_FLT_CH_NUM = 6;

  typedef logic [$clog2(HV_FLT_CH_NUM)-1:0] hv_flt_id_t;

  // Self-test sequencer states, one channel visited per INJ..WAIT_L pass
  typedef enum logic [2:0] {
    BIST_IDLE   = 3'd0,
    BIST_INJ    = 3'd1,
    BIST_WAIT_H = 3'd2,
    BIST_REL    = 3'd3,
    BIST_WAIT_L = 3'd4,
    BIST_DONE   = 3'd5
  } hv_flt_bist_st_e;

endpackage

// File: rtl/hv_flt_dgl.sv
// One fault channel: 2-flop synchroniser, self-test force, symmetric deglitch.
// live toggles once the synced input has disagreed with it for thr+1 cycles.
module hv_flt_dgl #(
  parameter int DGL_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_raw,
  input  logic             i_force,
  input  logic [DGL_W-1:0] i_thr,
  output logic             o_live
);

  logic             meta_q, sync_q, live_q, live_d;
  logic [DGL_W-1:0] cnt_q, cnt_d;
  logic             sync_eff;

  // Bring the asynchronous flag into the clock domain
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= i_raw;
      sync_q <= meta_q;
    end
  end

  // Self-test injects after the synchroniser so it is seen on the next deglitch step
  assign sync_eff = i_force | sync_q;

  // Count consecutive disagreement; toggle once the count reaches the threshold
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    live_d = live_q;
    cnt_d  = '0;
    if (sync_eff != live_q) begin
      if (cnt_q >= i_thr) live_d = ~live_q;
      else                cnt_d  = cnt_q + 1'b1;
    end
  end

  // Deglitch state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      live_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      live_q <= live_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_live = live_q;

endmodule

// File: rtl/hv_flt_mon.sv
// N-channel HV fault monitor: per-channel deglitch, sticky status, first-fault
// record and a single registered IRQ. Define HV_FLT_BIST_EN to build the
// self-test sequencer that injects each channel in turn; without it the BIST
// outputs are tied low and i_bist_start is ignored.
module hv_flt_mon
  import hv_pkg::*;
#(
  parameter int CH_NUM  = HV_FLT_CH_NUM,
  parameter int DGL_W   = 6,
  parameter int BIST_TO = 80
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [CH_NUM-1:0]         i_flt_raw,
  input  logic [CH_NUM-1:0]         i_flt_mask,
  input  logic [CH_NUM*DGL_W-1:0]   i_dgl_thr,
  input  logic                      i_clr_vld,
  input  logic [CH_NUM-1:0]         i_clr_mask,
  output logic [CH_NUM-1:0]         o_flt_live,
  output logic [CH_NUM-1:0]         o_flt_sticky,
  output logic                      o_first_vld,
  output logic [$clog2(CH_NUM)-1:0] o_first_id,
  output logic                      o_flt_irq,
  input  logic                      i_bist_start,
  output logic                      o_bist_busy,
  output logic                      o_bist_done,
  output logic [CH_NUM-1:0]         o_bist_pass
);

  localparam int ID_W = $clog2(CH_NUM);

  logic [CH_NUM-1:0] live, inj, clr, sticky_q, sticky_d;
  logic              first_vld_q, first_vld_d, irq_q;
  logic [ID_W-1:0]   first_id_q, first_id_d;
  logic              busy;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    hv_flt_dgl #(.DGL_W(DGL_W)) u_dgl (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_raw   (i_flt_raw[k]),
      .i_force (inj[k]),
      .i_thr   (i_dgl_thr[k*DGL_W +: DGL_W]),
      .o_live  (live[k])
    );
  end

  // Sticky next state: set dominates clear; frozen while self-test runs
  always_comb begin
    clr      = (i_clr_vld && !busy) ? i_clr_mask : '0;
    sticky_d = busy ? sticky_q : ((sticky_q & ~clr) | (live & ~i_flt_mask));
  end

  // First fault: capture lowest newly set index when sticky leaves all-zero
  always_comb begin
    first_vld_d = first_vld_q;
    first_id_d  = first_id_q;
    if (!busy && (sticky_q == '0)) begin
      first_vld_d = |sticky_d;
      first_id_d  = '0;
      for (int k = CH_NUM - 1; k >= 0; k--) begin
        if (sticky_d[k]) first_id_d = ID_W'(k);
      end
    end
  end

  // Status registers; IRQ follows next-state sticky so it appears with it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sticky_q    <= '0;
      first_vld_q <= 1'b0;
      first_id_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      sticky_q    <= sticky_d;
      first_vld_q <= first_vld_d;
      first_id_q  <= first_id_d;
      irq_q       <= |sticky_d;
    end
  end

  assign o_flt_live   = live;
  assign o_flt_sticky = sticky_q;
  assign o_first_vld  = first_vld_q;
  assign o_first_id   = first_id_q;
  assign o_flt_irq    = irq_q;

`ifdef HV_FLT_BIST_EN
  localparam int TMR_W = $clog2(BIST_TO + 1);

  hv_flt_bist_st_e   st_q, st_d;
  logic [ID_W-1:0]   ch_q, ch_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [CH_NUM-1:0] pass_q, pass_d;
  logic              last_ch, tmo;

  assign last_ch = (ch_q == ID_W'(CH_NUM - 1));
  assign tmo     = (tmr_q == TMR_W'(BIST_TO - 1));

  // Self-test sequencer: force high, see live rise, release, see live fall
  always_comb begin
    st_d   = st_q;
    ch_d   = ch_q;
    tmr_d  = tmr_q;
    pass_d = pass_q;
    inj    = '0;
    unique case (st_q)
      BIST_IDLE: begin
        if (i_bist_start) begin
          st_d   = BIST_INJ;
          ch_d   = '0;
          pass_d = '0;
        end
      end
      BIST_INJ: begin
        inj[ch_q] = 1'b1;
        tmr_d     = '0;
        st_d      = BIST_WAIT_H;
      end
      BIST_WAIT_H: begin
        inj[ch_q] = 1'b1;
        if (live[ch_q]) begin
          st_d = BIST_REL;
        end else if (tmo) begin
          st_d = last_ch ? BIST_DONE : BIST_INJ;
          ch_d = last_ch ? ch_q : ch_q + 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      BIST_REL: begin
        tmr_d = '0;
        st_d  = BIST_WAIT_L;
      end
      BIST_WAIT_L: begin
        if (!live[ch_q] || tmo) begin
          if (!live[ch_q]) pass_d[ch_q] = 1'b1;
          st_d = last_ch ? BIST_DONE : BIST_INJ;
          ch_d = last_ch ? ch_q : ch_q + 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      BIST_DONE: st_d = BIST_IDLE;
      default:   st_d = BIST_IDLE;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q   <= BIST_IDLE;
      ch_q   <= '0;
      tmr_q  <= '0;
      pass_q <= '0;
    end else begin
      st_q   <= st_d;
      ch_q   <= ch_d;
      tmr_q  <= tmr_d;
      pass_q <= pass_d;
    end
  end

  assign busy        = (st_q != BIST_IDLE) && (st_q != BIST_DONE);
  assign o_bist_busy = busy;
  assign o_bist_done = (st_q == BIST_DONE);
  assign o_bist_pass = pass_q;
`else
  logic unused_bist_start;
  assign unused_bist_start = i_bist_start;
  assign inj         = '0;
  assign busy        = 1'b0;
  assign o_bist_busy = 1'b0;
  assign o_bist_done = 1'b0;
  assign o_bist_pass = '0;
`endif

endmodule

// File: tb/tb_hv_flt_mon.sv
// Bench for hv_flt_mon: deglitch latency table with a scoreboard queue, then
// hand sequences for sticky/first-fault/IRQ, masking, threshold change,
// self-test (when HV_FLT_BIST_EN is defined) and reset.
module tb_hv_flt_mon;
  import hv_pkg::*;

  localparam int CH = 6;
  localparam int W  = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH-1:0]   raw, mask, clr_mask;
  logic [CH*W-1:0] thr;
  logic            clr_vld, bist_start;
  logic [CH-1:0]   live, sticky, pass;
  logic            first_vld, irq, busy, done;
  hv_flt_id_t      first_id;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  hv_flt_mon #(.CH_NUM(CH), .DGL_W(W), .BIST_TO(80)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flt_raw(raw), .i_flt_mask(mask),
    .i_dgl_thr(thr), .i_clr_vld(clr_vld), .i_clr_mask(clr_mask),
    .o_flt_live(live), .o_flt_sticky(sticky), .o_first_vld(first_vld),
    .o_first_id(first_id), .o_flt_irq(irq), .i_bist_start(bist_start),
    .o_bist_busy(busy), .o_bist_done(done), .o_bist_pass(pass)
  );

  always @(negedge clk) if (done === 1'b1) done_cnt++;

`ifdef HV_FLT_BIST_EN
  // Second instance with a short timeout so a slow channel fails self-test
  logic [CH-1:0] to_live, to_sticky, to_pass;
  logic          to_first_vld, to_irq, to_busy, to_done;
  hv_flt_id_t    to_first_id;
  int            to_done_cnt = 0;

  hv_flt_mon #(.CH_NUM(CH), .DGL_W(W), .BIST_TO(40)) u_dut_to (
    .i_clk(clk), .i_rst_n(rst_n), .i_flt_raw(raw), .i_flt_mask(mask),
    .i_dgl_thr(thr), .i_clr_vld(clr_vld), .i_clr_mask(clr_mask),
    .o_flt_live(to_live), .o_flt_sticky(to_sticky), .o_first_vld(to_first_vld),
    .o_first_id(to_first_id), .o_flt_irq(to_irq), .i_bist_start(bist_start),
    .o_bist_busy(to_busy), .o_bist_done(to_done), .o_bist_pass(to_pass)
  );

  always @(negedge clk) if (to_done === 1'b1) to_done_cnt++;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_thr(input int ch, input int v);
    thr[ch*W +: W] = W'(v);
  endtask

  // Drop all faults, let live settle, clear every sticky bit
  task automatic clean();
    raw = '0;
    mask = '0;
    repeat (70) tick();
    clr_vld = 1'b1;
    clr_mask = '1;
    tick();
    clr_vld = 1'b0;
    clr_mask = '0;
    tick();
  endtask

  typedef struct {
    int ch;
    int thr;
    int len;   // raw high time in clk
    int rise;  // edge count from raw rise to live rise, 0 = never
    int fall;  // edge count from raw rise to live fall, 0 = never
  } dgl_vec_t;

  typedef struct {
    int idx;
    int rise;
    int fall;
  } sb_t;

  dgl_vec_t vecs[7];
  sb_t      sb_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    raw = '0; mask = '0; thr = '0;
    clr_vld = 1'b0; clr_mask = '0; bist_start = 1'b0;

    // latency = thr+3 when the pulse covers thr+1 synced cycles, else dropped
    vecs[0] = '{ch: 0, thr: 4,  len: 4,  rise: 0,  fall: 0};
    vecs[1] = '{ch: 0, thr: 4,  len: 20, rise: 7,  fall: 27};
    vecs[2] = '{ch: 2, thr: 0,  len: 1,  rise: 3,  fall: 4};
    vecs[3] = '{ch: 5, thr: 3,  len: 3,  rise: 0,  fall: 0};
    vecs[4] = '{ch: 5, thr: 3,  len: 4,  rise: 6,  fall: 10};
    vecs[5] = '{ch: 1, thr: 10, len: 15, rise: 13, fall: 28};
    vecs[6] = '{ch: 3, thr: 1,  len: 2,  rise: 4,  fall: 6};

    repeat (3) tick();
    check("reset_outputs",
          {live, sticky, first_vld, first_id, irq, busy, done, pass}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Deglitch latency table
    for (int i = 0; i < 7; i++) begin
      int rise_at, fall_at;
      sb_t exp;
      thr = '0;
      set_thr(vecs[i].ch, vecs[i].thr);
      sb_q.push_back('{idx: i, rise: vecs[i].rise, fall: vecs[i].fall});
      raw[vecs[i].ch] = 1'b1;
      rise_at = 0;
      fall_at = 0;
      for (int n = 1; n <= vecs[i].len + vecs[i].thr + 8; n++) begin
        tick();
        if (n == vecs[i].len) raw[vecs[i].ch] = 1'b0;
        if (live[vecs[i].ch] === 1'b1 && rise_at == 0) rise_at = n;
        if (live[vecs[i].ch] === 1'b0 && rise_at != 0 && fall_at == 0) fall_at = n;
      end
      exp = sb_q.pop_front();
      check($sformatf("dgl_rise[%0d]", exp.idx), rise_at, exp.rise);
      check($sformatf("dgl_fall[%0d]", exp.idx), fall_at, exp.fall);
      clean();
    end

    // Single fault: sticky, IRQ and first record one cycle after live
    thr = '0;
    set_thr(0, 4);
    raw[0] = 1'b1;
    repeat (7) tick();
    check("t1_live", live, 6'h01);
    check("t1_sticky_pre", sticky, 6'h00);
    tick();
    check("t1_sticky", sticky, 6'h01);
    check("t1_irq", irq, 1'b1);
    check("t1_first", {first_vld, first_id}, {1'b1, 3'd0});
    clean();

    // Simultaneous faults: lowest index wins, record held on later faults
    thr = '0;
    raw = 6'b001010;
    repeat (4) tick();
    check("t2_sticky", sticky, 6'b001010);
    check("t2_first", {first_vld, first_id}, {1'b1, 3'd1});
    raw[0] = 1'b1;
    repeat (4) tick();
    check("t2_first_held", {sticky, first_id}, {6'b001011, 3'd1});
    clean();

    // Clear while active is ignored; clear after release empties status
    raw[2] = 1'b1;
    repeat (4) tick();
    clr_vld = 1'b1;
    clr_mask = 6'b000100;
    tick();
    clr_vld = 1'b0;
    check("t3_clr_active", sticky, 6'b000100);
    raw[2] = 1'b0;
    repeat (4) tick();
    check("t3_live_low", {live, sticky}, {6'h00, 6'b000100});
    clr_vld = 1'b1;
    tick();
    clr_vld = 1'b0;
    clr_mask = '0;
    check("t3_cleared", {sticky, irq, first_vld}, {6'h00, 1'b0, 1'b1});
    tick();
    check("t3_first_drop", {first_vld, first_id}, {1'b0, 3'd0});

    // Masked channel: live only; unmask sets sticky; re-mask keeps it
    mask = 6'b010000;
    raw[4] = 1'b1;
    repeat (4) tick();
    check("t4_masked", {live, sticky, irq}, {6'b010000, 6'h00, 1'b0});
    mask = '0;
    tick();
    check("t4_unmasked", {sticky, irq, first_vld, first_id}, {6'b010000, 1'b1, 1'b1, 3'd4});
    mask = 6'b010000;
    tick();
    check("t4_remask_keeps", sticky, 6'b010000);
    clean();

    // Threshold lowered below the running count toggles on the next edge
    thr = '0;
    set_thr(0, 20);
    raw[0] = 1'b1;
    repeat (10) tick();
    check("thr_chg_before", live[0], 1'b0);
    set_thr(0, 5);
    tick();
    check("thr_chg_after", live[0], 1'b1);
    clean();

`ifdef HV_FLT_BIST_EN
    begin
      int base, to_base;
      for (int k = 0; k < CH; k++) set_thr(k, 2);
      base = done_cnt;
      to_base = to_done_cnt;
      bist_start = 1'b1;
      tick();
      bist_start = 1'b0;
      check("bist1_busy", {busy, to_busy}, 2'b11);
      repeat (5) tick();
      bist_start = 1'b1;  // ignored while busy
      tick();
      bist_start = 1'b0;
      for (int n = 0; n < 1000 && (done_cnt == base || to_done_cnt == to_base); n++) tick();
      repeat (5) tick();
      check("bist1_done_cnt", done_cnt - base, 1);
      check("bist1_pass", {pass, to_pass}, {6'h3F, 6'h3F});
      check("bist1_frozen", {busy, sticky, irq, first_vld}, 32'd0);

      set_thr(5, 63);
      base = done_cnt;
      to_base = to_done_cnt;
      bist_start = 1'b1;
      tick();
      bist_start = 1'b0;
      check("bist2_pass_clr", {pass, to_pass}, 12'h000);
      for (int n = 0; n < 2000 && (done_cnt == base || to_done_cnt == to_base); n++) tick();
      repeat (5) tick();
      check("bist2_done_cnt", {done_cnt - base, to_done_cnt - to_base}, {16'd1, 16'd1});
      check("bist2_pass", {pass, to_pass}, {6'h3F, 6'h1F});
    end
`else
    begin
      int base;
      base = done_cnt;
      bist_start = 1'b1;
      tick();
      bist_start = 1'b0;
      repeat (5) tick();
      check("bist_off", {busy, pass}, 32'd0);
      check("bist_off_done", done_cnt - base, 0);
    end
`endif

    // Reset mid-deglitch (and mid-self-test when built in)
    thr = '0;
    for (int k = 0; k < CH; k++) set_thr(k, 4);
    raw = '0;
    tick();
    bist_start = 1'b1;
    tick();
    bist_start = 1'b0;
    raw[0] = 1'b1;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1 check("rst_async",
             {live, sticky, first_vld, first_id, irq, busy, done, pass}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("rst_redetect_early", live[0], 1'b0);
    tick();
    check("rst_redetect", live[0], 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
